ama_riscv_imem_ctrl: RTL and testbench

- Boot/load sequencer and read-port arbiter in front of the 16K x 32 instruction memory.
- After reset it holds the core stalled while a loader (UART bootloader / bench) streams the program image into IMEM through the write port; it then releases the core.
- In RUN it shares the single synchronous read port between core fetch and loader read-back.
- Sits between ama_riscv_core fetch, the loader, and the IMEM macro.

---
 rtl/ama_riscv_imem_pkg.sv | 20 ++
 rtl/ama_riscv_imem_rd_arb.sv | 81 ++++++++
 rtl/ama_riscv_imem_ctrl.sv | 112 +++++++++++
 tb/tb_ama_riscv_imem_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ama_riscv_imem_pkg.sv
// ama_riscv_imem_pkg: shared constants and types for the IMEM controller.
// Exports: ADDR_W, DATA_W, DEPTH, imem_ctrl_state_t, rd_owner_t.
package ama_riscv_imem_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16384;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } imem_ctrl_state_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_LDR  = 1'b1
    } rd_owner_t;

endpackage

// File: rtl/ama_riscv_imem_rd_arb.sv
// ama_riscv_imem_rd_arb: 2-way arbiter for the IMEM synchronous read port.
// Ports: en gates all grants; core_*/ldr_* request, grant, rvalid, rdata;
// imem_addrb/imem_doutb drive the read port (1-cycle read latency).
// Option: IMEM_CTRL_RR_EN selects round-robin, else fixed core priority.
module ama_riscv_imem_rd_arb #(
    parameter int ADDR_W = ama_riscv_imem_pkg::ADDR_W,
    parameter int DATA_W = ama_riscv_imem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              core_req,
    input  logic [ADDR_W-1:0] core_addr,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              ldr_rreq,
    input  logic [ADDR_W-1:0] ldr_raddr,
    output logic              ldr_rgnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic [ADDR_W-1:0] imem_addrb,
    input  logic [DATA_W-1:0] imem_doutb
);
    import ama_riscv_imem_pkg::*;

    rd_owner_t         own_q;
    logic              pend_q;
    logic              ldr_wins;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] crd_q;
    logic [DATA_W-1:0] lrd_q;

`ifdef IMEM_CTRL_RR_EN
    // last winner of a contested cycle; only contests move it
    rd_owner_t last_q;

    assign ldr_wins = ldr_rreq & (~core_req | (last_q == OWN_CORE));

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= OWN_LDR;
        end else if (en && core_req && ldr_rreq) begin
            last_q <= ldr_wins ? OWN_LDR : OWN_CORE;
        end
    end
`else
    assign ldr_wins = ldr_rreq & ~core_req;
`endif

    assign ldr_rgnt  = en & ldr_wins;
    assign core_gnt  = en & core_req & ~ldr_wins;

    // address is sampled by the macro, so hold it when nobody reads
    assign imem_addrb = core_gnt ? core_addr :
                        ldr_rgnt ? ldr_raddr : addr_q;

    assign core_rvalid = pend_q & (own_q == OWN_CORE);
    assign ldr_rvalid  = pend_q & (own_q == OWN_LDR);
    assign core_rdata  = core_rvalid ? imem_doutb : crd_q;
    assign ldr_rdata   = ldr_rvalid  ? imem_doutb : lrd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= 1'b0;
            own_q  <= OWN_CORE;
            addr_q <= '0;
            crd_q  <= '0;
            lrd_q  <= '0;
        end else begin
            pend_q <= core_gnt | ldr_rgnt;
            if (core_gnt || ldr_rgnt) begin
                own_q <= ldr_rgnt ? OWN_LDR : OWN_CORE;
            end
            addr_q <= imem_addrb;
            crd_q  <= core_rdata;
            lrd_q  <= ldr_rdata;
        end
    end

endmodule

// File: rtl/ama_riscv_imem_ctrl.sv
// ama_riscv_imem_ctrl: boot/load sequencer and read arbiter for the IMEM.
// Ports: core fetch (req/gnt/rvalid/rdata/stall), loader write + read-back,
// IMEM port a (write) and port b (read), load_cnt and state observability.
// Option: IMEM_CTRL_RR_EN enables round-robin read arbitration.
module ama_riscv_imem_ctrl #(
    parameter int ADDR_W    = ama_riscv_imem_pkg::ADDR_W,
    parameter int DATA_W    = ama_riscv_imem_pkg::DATA_W,
    parameter int DEPTH     = ama_riscv_imem_pkg::DEPTH,
    parameter bit BOOT_LOAD = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic [ADDR_W-1:0] core_addr,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              ldr_wvalid,
    input  logic [ADDR_W-1:0] ldr_waddr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_wready,
    input  logic              ldr_done,
    input  logic              ldr_reload,
    input  logic              ldr_rreq,
    input  logic [ADDR_W-1:0] ldr_raddr,
    output logic              ldr_rgnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addra,
    output logic [DATA_W-1:0] imem_dina,
    output logic [ADDR_W-1:0] imem_addrb,
    input  logic [DATA_W-1:0] imem_doutb,
    output logic [ADDR_W:0]   load_cnt,
    output logic [1:0]        state
);
    import ama_riscv_imem_pkg::*;

    localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);

    imem_ctrl_state_t st;
    logic             wr_acc;
    logic             rd_en;
    logic [ADDR_W:0]  cnt_nxt;

    assign state      = st;
    assign core_stall = (st != RUN);
    // rst gates the write port so nothing reaches IMEM during reset
    assign ldr_wready = ~rst & (st != RUN);
    assign wr_acc     = ldr_wvalid & ldr_wready;
    assign imem_we    = wr_acc;
    assign imem_addra = ldr_waddr;
    assign imem_dina  = ldr_wdata;
    assign rd_en      = ~rst & (st == RUN);

    assign cnt_nxt = (wr_acc && load_cnt != CNT_MAX) ?
                     load_cnt + 1'b1 : load_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= IDLE;
            load_cnt <= '0;
        end else begin
            unique case (st)
                IDLE: begin
                    if (wr_acc) begin
                        st       <= LOAD;
                        load_cnt <= cnt_nxt;
                    end else if (!BOOT_LOAD) begin
                        st <= RUN;
                    end
                end
                LOAD: begin
                    load_cnt <= cnt_nxt;
                    if (ldr_done || cnt_nxt == CNT_MAX) begin
                        st <= RUN;
                    end
                end
                RUN: begin
                    if (ldr_reload) begin
                        st       <= IDLE;
                        load_cnt <= '0;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    ama_riscv_imem_rd_arb #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rd_arb (
        .clk         (clk),
        .rst         (rst),
        .en          (rd_en),
        .core_req    (core_req),
        .core_addr   (core_addr),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .ldr_rreq    (ldr_rreq),
        .ldr_raddr   (ldr_raddr),
        .ldr_rgnt    (ldr_rgnt),
        .ldr_rvalid  (ldr_rvalid),
        .ldr_rdata   (ldr_rdata),
        .imem_addrb  (imem_addrb),
        .imem_doutb  (imem_doutb)
    );

endmodule

// File: tb/tb_ama_riscv_imem_ctrl.sv
// tb_ama_riscv_imem_ctrl: directed + random bench for ama_riscv_imem_ctrl.
// Honours IMEM_CTRL_RR_EN for the expected arbitration order.
module tb_ama_riscv_imem_ctrl;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int DEP = 16384;
`ifdef IMEM_CTRL_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, core_req, ldr_wvalid, ldr_done, ldr_reload, ldr_rreq;
    logic [AW-1:0] core_addr, ldr_waddr, ldr_raddr;
    logic [DW-1:0] ldr_wdata, imem_doutb;
    logic          core_gnt, core_rvalid, core_stall, ldr_wready;
    logic          ldr_rgnt, ldr_rvalid, imem_we;
    logic [DW-1:0] core_rdata, ldr_rdata, imem_dina;
    logic [AW-1:0] imem_addra, imem_addrb;
    logic [AW:0]   load_cnt;
    logic [1:0]    state;

    // second instance: image preloaded, no boot load
    logic          b_core_gnt, b_core_rvalid, b_core_stall, b_ldr_wready;
    logic          b_ldr_rgnt, b_ldr_rvalid, b_imem_we;
    logic [DW-1:0] b_core_rdata, b_ldr_rdata, b_imem_dina;
    logic [AW-1:0] b_imem_addra, b_imem_addrb;
    logic [AW:0]   b_load_cnt;
    logic [1:0]    b_state;
    logic [DW-1:0] b_doutb = '0;

    ama_riscv_imem_ctrl dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_addr(core_addr),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid),
        .core_rdata(core_rdata), .core_stall(core_stall),
        .ldr_wvalid(ldr_wvalid), .ldr_waddr(ldr_waddr),
        .ldr_wdata(ldr_wdata), .ldr_wready(ldr_wready),
        .ldr_done(ldr_done), .ldr_reload(ldr_reload),
        .ldr_rreq(ldr_rreq), .ldr_raddr(ldr_raddr),
        .ldr_rgnt(ldr_rgnt), .ldr_rvalid(ldr_rvalid),
        .ldr_rdata(ldr_rdata), .imem_we(imem_we),
        .imem_addra(imem_addra), .imem_dina(imem_dina),
        .imem_addrb(imem_addrb), .imem_doutb(imem_doutb),
        .load_cnt(load_cnt), .state(state)
    );

    ama_riscv_imem_ctrl #(.BOOT_LOAD(1'b0)) dut_b (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_addr(core_addr),
        .core_gnt(b_core_gnt), .core_rvalid(b_core_rvalid),
        .core_rdata(b_core_rdata), .core_stall(b_core_stall),
        .ldr_wvalid(ldr_wvalid), .ldr_waddr(ldr_waddr),
        .ldr_wdata(ldr_wdata), .ldr_wready(b_ldr_wready),
        .ldr_done(ldr_done), .ldr_reload(ldr_reload),
        .ldr_rreq(ldr_rreq), .ldr_raddr(ldr_raddr),
        .ldr_rgnt(b_ldr_rgnt), .ldr_rvalid(b_ldr_rvalid),
        .ldr_rdata(b_ldr_rdata), .imem_we(b_imem_we),
        .imem_addra(b_imem_addra), .imem_dina(b_imem_dina),
        .imem_addrb(b_imem_addrb), .imem_doutb(b_doutb),
        .load_cnt(b_load_cnt), .state(b_state)
    );

    // behavioural IMEM macro
    logic [DW-1:0] mem [DEP];
    always @(posedge clk) begin
        if (imem_we) mem[imem_addra] <= imem_dina;
        imem_doutb <= mem[imem_addrb];
    end

    // reference model
    logic [DW-1:0] ref_mem [DEP];
    bit            last_ldr;
    logic [DW-1:0] exp_c, exp_l;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        last_ldr = 1'b1;
        exp_c    = '0;
        exp_l    = '0;
    endtask

    task automatic rd_cycle(input bit cr, input logic [AW-1:0] ca,
                            input bit lr, input logic [AW-1:0] la);
        bit gc, gl;
        core_req  = cr;
        core_addr = ca;
        ldr_rreq  = lr;
        ldr_raddr = la;
        #1;
        gl = lr && (!cr || (RR && !last_ldr));
        gc = cr && !gl;
        chk("core_gnt", core_gnt, gc);
        chk("ldr_rgnt", ldr_rgnt, gl);
        if (gc || gl) chk("imem_addrb", imem_addrb, gc ? ca : la);
        if (cr && lr) last_ldr = gl;
        tick();
        if (gc) exp_c = ref_mem[ca];
        if (gl) exp_l = ref_mem[la];
        chk("core_rvalid", core_rvalid, gc);
        chk("ldr_rvalid", ldr_rvalid, gl);
        chk("core_rdata", core_rdata, exp_c);
        chk("ldr_rdata", ldr_rdata, exp_l);
    endtask

    initial begin
        for (int i = 0; i < DEP; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        model_reset();
        rst = 1'b1;
        core_req = 0; core_addr = '0; ldr_rreq = 0; ldr_raddr = '0;
        ldr_wvalid = 0; ldr_waddr = '0; ldr_wdata = '0;
        ldr_done = 0; ldr_reload = 0;
        tick();
        tick();
        chk("rst_state", state, 0);
        chk("rst_cnt", load_cnt, 0);
        chk("rst_stall", core_stall, 1);
        chk("rst_we", imem_we, 0);
        chk("rst_rvalid", core_rvalid, 0);
        chk("rst_rdata", core_rdata, 0);
        chk("rst_b_state", b_state, 0);
        rst = 1'b0;
        tick();
        chk("boot_state", state, 0);
        chk("b_run_state", b_state, 2);
        chk("b_run_stall", b_core_stall, 0);

        // four-word image then done
        for (int i = 0; i < 4; i++) begin
            ldr_wvalid = 1'b1;
            ldr_waddr  = AW'(i);
            ldr_wdata  = 32'hA0 + 32'(i);
            ref_mem[i] = ldr_wdata;
            #1;
            chk("ld_wready", ldr_wready, 1);
            chk("ld_we", imem_we, 1);
            chk("ld_addra", imem_addra, i);
            chk("ld_stall", core_stall, 1);
            tick();
            chk("ld_state", state, 1);
            chk("ld_cnt", load_cnt, i + 1);
        end
        ldr_wvalid = 1'b0;
        ldr_done   = 1'b1;
        tick();
        ldr_done = 1'b0;
        chk("done_state", state, 2);
        chk("done_stall", core_stall, 0);
        chk("done_cnt", load_cnt, 4);

        rd_cycle(1, 2, 0, 0);
        chk("core_a2", core_rdata, 32'hA2);
        rd_cycle(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) rd_cycle(1, 1, 1, 3);
        rd_cycle(0, 0, 0, 0);
        for (int i = 0; i < 40; i++)
            rd_cycle($urandom_range(0, 1), AW'($urandom_range(0, 7)),
                     $urandom_range(0, 1), AW'($urandom_range(0, 7)));

        // reload with a fetch in flight
        core_req = 1'b1; core_addr = 1; ldr_rreq = 1'b0;
        ldr_reload = 1'b1;
        #1;
        chk("rl_gnt", core_gnt, 1);
        tick();
        core_req = 1'b0; ldr_reload = 1'b0;
        exp_c = ref_mem[1];
        chk("rl_rvalid", core_rvalid, 1);
        chk("rl_rdata", core_rdata, exp_c);
        chk("rl_state", state, 0);
        chk("rl_stall", core_stall, 1);
        chk("rl_cnt", load_cnt, 0);

        // full-depth load without done
        for (int i = 0; i < DEP; i++) begin
            ldr_wvalid = 1'b1;
            ldr_waddr  = AW'(i);
            ldr_wdata  = $urandom;
            ref_mem[i] = ldr_wdata;
            if (i == DEP - 1) begin
                #1;
                chk("full_pre_cnt", load_cnt, DEP - 1);
                chk("full_pre_state", state, 1);
            end
            tick();
        end
        chk("full_state", state, 2);
        chk("full_cnt", load_cnt, DEP);
        ldr_waddr = 0;
        ldr_wdata = 32'hDEADBEEF;
        #1;
        chk("full_wready", ldr_wready, 0);
        chk("full_we", imem_we, 0);
        tick();
        ldr_wvalid = 1'b0;
        chk("full_hold", load_cnt, DEP);
        rd_cycle(0, 0, 1, 0);
        for (int i = 0; i < 40; i++)
            rd_cycle($urandom_range(0, 1), AW'($urandom),
                     $urandom_range(0, 1), AW'($urandom));
        rd_cycle(0, 0, 0, 0);

        // reset in the middle of a load
        ldr_reload = 1'b1;
        tick();
        ldr_reload = 1'b0;
        chk("rl2_state", state, 0);
        for (int i = 0; i < 2; i++) begin
            ldr_wvalid = 1'b1;
            ldr_waddr  = AW'(5 + i);
            ldr_wdata  = $urandom;
            ldr_reload = (i == 1);
            tick();
        end
        ldr_reload = 1'b0;
        chk("mid_state", state, 1);
        chk("mid_cnt", load_cnt, 2);
        rst = 1'b1;
        #1;
        chk("mr_we", imem_we, 0);
        tick();
        model_reset();
        chk("mr_state", state, 0);
        chk("mr_cnt", load_cnt, 0);
        chk("mr_stall", core_stall, 1);
        chk("mr_we2", imem_we, 0);
        chk("mr_rdata", core_rdata, 0);
        rst = 1'b0;
        ldr_wvalid = 1'b0;
        ldr_done = 1'b1;
        tick();
        ldr_done = 1'b0;
        chk("idle_done_ign", state, 0);
        chk("b_rerun", b_state, 2);
        chk("mr_rvalid", core_rvalid, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
